// File: rtl/act_ctrl_pkg.sv
// Shared constants for the activation sequencer: default widths, FSM state codes,
// activation-type codes and the saturating increment used by the performance counters.
package act_ctrl_pkg;

   localparam int DEF_DWIDTH       = 8;
   localparam int DEF_MAT_MUL_SIZE = 4;
   localparam int DEF_AWIDTH       = 10;
   localparam int DEF_MASK_WIDTH   = 4;
   localparam int PERF_W           = 32;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE  = 3'd0;
   localparam state_t ST_READ  = 3'd1;
   localparam state_t ST_ISSUE = 3'd2;
   localparam state_t ST_WAIT  = 3'd3;
   localparam state_t ST_WRITE = 3'd4;
   localparam state_t ST_DONE  = 3'd5;

   localparam logic ACT_RELU = 1'b0;
   localparam logic ACT_TANH = 1'b1;

   function automatic logic [PERF_W-1:0] sat_inc(input logic [PERF_W-1:0] v);
      return (&v) ? v : v + 1'b1;
   endfunction

endpackage

// File: rtl/act_ctrl_perf.sv
// Busy-cycle and write-stall counters; cleared by clear_i, saturate at all-ones, hold otherwise.
// One cycle update latency; purely observational, never stalls anything.
module act_ctrl_perf
   import act_ctrl_pkg::*;
(
   input  logic              clk,
   input  logic              resetn,
   input  logic              clear_i,
   input  logic              busy_i,
   input  logic              stall_i,
   output logic [PERF_W-1:0] busy_cycles_o,
   output logic [PERF_W-1:0] stall_cycles_o
);

   logic [PERF_W-1:0] busy_q, busy_d;
   logic [PERF_W-1:0] stall_q, stall_d;

   always_comb begin
      busy_d  = busy_q;
      stall_d = stall_q;
      if (clear_i) begin
         busy_d  = '0;
         stall_d = '0;
      end else begin
         if (busy_i)  busy_d  = sat_inc(busy_q);
         if (stall_i) stall_d = sat_inc(stall_q);
      end
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         busy_q  <= '0;
         stall_q <= '0;
      end else begin
         busy_q  <= busy_d;
         stall_q <= stall_d;
      end
   end

   assign busy_cycles_o  = busy_q;
   assign stall_cycles_o = stall_q;

endmodule

// File: rtl/activation_ctrl.sv
// Row sequencer: result RAM read -> activation issue -> capture -> output RAM write (ACT_CTRL_PERF_EN adds perf counters).
// 4 cycles/row with activation, 3 in bypass; WRITE holds dst_we/addr/data until dst_ready.
module activation_ctrl
   import act_ctrl_pkg::*;
#(
   parameter int DWIDTH       = DEF_DWIDTH,
   parameter int MAT_MUL_SIZE = DEF_MAT_MUL_SIZE,
   parameter int AWIDTH       = DEF_AWIDTH,
   parameter int MASK_WIDTH   = DEF_MASK_WIDTH
)(
   input  logic                           clk,
   input  logic                           resetn,
   input  logic                           start,
   input  logic                           abort,
   input  logic                           cfg_activation_type,
   input  logic                           cfg_enable_activation,
   input  logic [AWIDTH-1:0]              cfg_num_rows,
   input  logic [AWIDTH-1:0]              cfg_src_addr,
   input  logic [AWIDTH-1:0]              cfg_dst_addr,
   input  logic [MASK_WIDTH-1:0]          cfg_validity_mask,
   output logic                           busy,
   output logic                           done,
   output logic                           src_en,
   output logic [AWIDTH-1:0]              src_addr,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] src_data,
   output logic                           act_type,
   output logic                           act_enable,
   output logic                           act_in_valid,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] act_in_data,
   output logic [MASK_WIDTH-1:0]          act_mask,
   input  logic                           act_out_valid,
   input  logic [MAT_MUL_SIZE*DWIDTH-1:0] act_out_data,
   output logic                           dst_we,
   output logic [AWIDTH-1:0]              dst_addr,
   output logic [MAT_MUL_SIZE*DWIDTH-1:0] dst_data,
   output logic [MASK_WIDTH-1:0]          dst_mask,
   input  logic                           dst_ready
`ifdef ACT_CTRL_PERF_EN
   ,
   output logic [PERF_W-1:0]              perf_busy_cycles,
   output logic [PERF_W-1:0]              perf_stall_cycles
`endif
);

   localparam int RW = MAT_MUL_SIZE*DWIDTH;

   state_t            state_q, state_d;
   logic [AWIDTH-1:0] row_q, row_d, row_inc;
   logic [AWIDTH-1:0] num_q, src_base_q, dst_base_q;
   logic              type_q, en_q;
   logic [MASK_WIDTH-1:0] mask_q;
   logic [RW-1:0]     res_q, res_d;
   logic              start_acc;
   logic              last_row;

   assign start_acc = (state_q == ST_IDLE) && start && !abort;
   assign row_inc   = row_q + 1'b1;
   assign last_row  = (row_inc == num_q);

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q <= ST_IDLE;
         row_q   <= '0;
         res_q   <= '0;
      end else begin
         state_q <= state_d;
         row_q   <= row_d;
         res_q   <= res_d;
      end
   end

   // Configuration is only sampled on an accepted start, so it stays frozen while busy.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         num_q      <= '0;
         src_base_q <= '0;
         dst_base_q <= '0;
         type_q     <= 1'b0;
         en_q       <= 1'b0;
         mask_q     <= '0;
      end else if (start_acc) begin
         num_q      <= cfg_num_rows;
         src_base_q <= cfg_src_addr;
         dst_base_q <= cfg_dst_addr;
         type_q     <= cfg_activation_type;
         en_q       <= cfg_enable_activation;
         mask_q     <= cfg_validity_mask;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (start_acc) state_d = (cfg_num_rows == '0) ? ST_DONE : ST_READ;
         ST_READ:  state_d = ST_ISSUE;
         // Bypass returns the row combinationally, so WAIT can be skipped.
         ST_ISSUE: state_d = act_out_valid ? ST_WRITE : ST_WAIT;
         ST_WAIT:  if (act_out_valid) state_d = ST_WRITE;
         ST_WRITE: if (dst_ready) state_d = last_row ? ST_DONE : ST_READ;
         ST_DONE:  state_d = ST_IDLE;
         default:  state_d = ST_IDLE;
      endcase
      if (abort) state_d = ST_IDLE;
   end

   always_comb begin
      row_d = row_q;
      res_d = res_q;
      if (start_acc) row_d = '0;
      if ((state_q == ST_WRITE) && dst_ready) row_d = row_inc;
      if (((state_q == ST_ISSUE) || (state_q == ST_WAIT)) && act_out_valid) res_d = act_out_data;
   end

   always_comb begin
      busy         = (state_q != ST_IDLE);
      done         = (state_q == ST_DONE);
      src_en       = (state_q == ST_READ);
      act_in_valid = (state_q == ST_ISSUE);
      dst_we       = (state_q == ST_WRITE);
      act_in_data  = (state_q == ST_ISSUE) ? src_data : '0;
      src_addr     = src_base_q + row_q;
      dst_addr     = dst_base_q + row_q;
      dst_data     = res_q;
      act_type     = type_q;
      act_enable   = en_q;
      act_mask     = mask_q;
      dst_mask     = mask_q;
   end

`ifdef ACT_CTRL_PERF_EN
   act_ctrl_perf u_perf (
      .clk            (clk),
      .resetn         (resetn),
      .clear_i        (start_acc),
      .busy_i         (busy),
      .stall_i        ((state_q == ST_WRITE) && !dst_ready),
      .busy_cycles_o  (perf_busy_cycles),
      .stall_cycles_o (perf_stall_cycles)
   );
`endif

endmodule
